// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch constants and state encoding
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} fetch_state_e;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction memory req/gnt/rvalid bus
interface if_stage_if;
  import riscv_pkg::*;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [XLEN-1:0] rdata;
  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_stage.sv
// if_stage: single-outstanding instruction fetch with redirect, kill and misalignment trap
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rstn,
  if_stage_if.master      imem,
  output logic [XLEN-1:0] instruct,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fetch_cnt
);
  fetch_state_e    r_state, w_state;
  logic [XLEN-1:0] r_pc, w_pc, r_instr, w_instr, r_pc_o, w_pc_o, r_cnt, w_cnt;
  logic            r_kill, w_kill, r_valid, w_valid, r_fault, w_fault, w_bad;
  assign w_bad       = redirect_valid && (redirect_pc[1:0] != 2'b00) && (r_state inside {REQ, WAIT, HOLD});
  assign imem.req    = (r_state == REQ) && !redirect_valid;
  assign imem.addr   = r_pc;
  assign instruct    = r_valid ? r_instr : NOP_INSTR;
  assign pc_o        = r_pc_o;
  assign instr_valid = r_valid;
  assign fetch_fault = r_fault;
  assign fetch_cnt   = r_cnt;
  // state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc_o  <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_kill  <= w_kill;
      r_instr <= w_instr;
      r_pc_o  <= w_pc_o;
      r_valid <= w_valid;
      r_fault <= w_fault;
      r_cnt   <= w_cnt;
    end
  end
  // next state: a misaligned redirect traps before anything else, a redirect during WAIT poisons the pending response
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_kill  = r_kill;
    w_instr = r_instr;
    w_pc_o  = r_pc_o;
    w_valid = r_valid;
    w_fault = r_fault;
    w_cnt   = r_cnt + {{(XLEN-1){1'b0}}, r_valid & id_ready};
    if (w_bad) begin
      w_state = FAULT;
      w_fault = 1'b1;
      w_valid = 1'b0;
      w_kill  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state = REQ;
          w_pc    = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : r_pc;
        end
        REQ: begin
          w_pc    = redirect_valid ? redirect_pc : r_pc;
          w_state = (!redirect_valid && imem.gnt) ? WAIT : REQ;
        end
        WAIT: begin
          if (imem.rvalid && (r_kill || redirect_valid)) begin
            w_kill  = 1'b0;
            w_state = REQ;
            w_pc    = redirect_valid ? redirect_pc : r_pc;
          end else if (imem.rvalid) begin
            w_instr = imem.rdata;
            w_pc_o  = r_pc;
            w_valid = 1'b1;
            w_pc    = r_pc + XLEN'(4);
            w_state = HOLD;
          end else if (redirect_valid) begin
            w_pc   = redirect_pc;
            w_kill = 1'b1;
          end
        end
        HOLD: begin
          w_pc    = redirect_valid ? redirect_pc : r_pc;
          w_valid = !(redirect_valid || id_ready);
          w_state = (redirect_valid || id_ready) ? REQ : HOLD;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch front end that sits directly upstream of the ID decoder and drives its instruct input.
- Holds the PC and issues one-at-a-time word reads to instruction memory over a req/gnt/rvalid handshake.
- Presents each fetched instruction to ID with a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage, flushing any fetch already in flight; traps misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instruct when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising-edge.
- rstn  input  1  asynchronous active-low reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  32  word-aligned byte address; equals pc whenever imem_req=1.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid; arrives at least 1 cycle after the grant.
- imem_rdata  input  32  instruction word.
- instruct  output  32  instruction to ID.
- pc_o  output  32  address of the instruction on instruct.
- instr_valid  output  1  instruct/pc_o are valid.
- id_ready  input  1  ID consumes the instruction this cycle.
- redirect_valid  input  1  single-cycle branch/jump redirect.
- redirect_pc  input  32  redirect target.
- fetch_fault  output  1  sticky misaligned-target flag.
- fetch_cnt  output  32  count of instructions handed to ID; wraps at 2^32.

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC, state=IDLE, kill=0.
  - imem_req=0, instr_valid=0, instruct=NOP_INSTR, pc_o=0, fetch_fault=0, fetch_cnt=0.
  - Reset mid-fetch abandons the transaction; any later imem_rvalid is ignored until the stage is back in WAIT.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
  - IDLE -> REQ unconditionally, giving one bubble cycle after reset release.
  - REQ:
    - imem_req = (state==REQ) && !redirect_valid, combinational; imem_addr=pc.
    - If redirect_valid: pc<=redirect_pc, stay in REQ.
    - Else if imem_gnt: -> WAIT.
  - WAIT, on imem_rvalid:
    - If kill=1 (or redirect_valid this same cycle): drop the data, kill<=0, -> REQ.
    - Otherwise: instruct<=imem_rdata, pc_o<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32), -> HOLD.
    - redirect_valid without rvalid: pc<=redirect_pc, kill<=1, stay in WAIT.
  - HOLD:
    - instruct and pc_o remain stable while instr_valid=1 and id_ready=0.
    - A transfer occurs when instr_valid && id_ready: fetch_cnt+=1, instr_valid<=0, instruct<=NOP_INSTR, -> REQ.
    - redirect_valid: pc<=redirect_pc, instr_valid<=0, -> REQ. If id_ready is also high, the transfer still counts.
  - FAULT: imem_req=0, instr_valid=0; stays in FAULT until reset.
- Redirect target check:
  - Any redirect_valid with redirect_pc[1:0]!=0, in any state other than IDLE: fetch_fault<=1, -> FAULT, pc is not updated.
  - Applies in WAIT as well; the outstanding response is then ignored.
- Redirect in IDLE: pc<=redirect_pc, then -> REQ normally. Alignment is not checked in IDLE.
- Minimum latency: 3 cycles per instruction with gnt in the REQ cycle, rvalid one cycle later, and id_ready high.
- At most one outstanding memory request at any time.
- imem_addr[1:0] is always 0.

Decomposition:
- Shared package riscv_pkg holds:
  - NOP_INSTR constant and the RESET_PC default.
  - Fetch state enum {IDLE, REQ, WAIT, HOLD, FAULT}.
  - XLEN=32.
- No sub-module is needed; the next-PC logic stays inline.

Test Plan:
- Straight-line fetch: reset release, memory with gnt=1 and 1-cycle rvalid returning 32'h0020F033 at 0x0, then words at 0x4 and 0x8, id_ready=1.
  - Required: pc_o 0x0, 0x4, 0x8 in order, one instruction every 3 cycles, fetch_cnt=3.
- Backpressure: id_ready=0 for 5 cycles while in HOLD.
  - Required: instruct and pc_o stable, no imem_req; fetch_cnt increments once when id_ready rises.
- Redirect in WAIT: redirect_pc=0x100 one cycle before rvalid for 0x4.
  - Required: the 0x4 data is dropped, next request is to 0x100, and pc_o=0x100 is delivered.
- Redirect and rvalid in the same cycle: stale data is dropped, next imem_addr=redirect_pc.
- Misaligned redirect_pc=0x102: fetch_fault=1, imem_req stays 0 indefinitely; rstn pulse clears fault and restarts fetch at RESET_PC.
- Async reset asserted mid-WAIT: outputs reach reset values without a clock edge; the late rvalid after release is ignored.
